// File: rtl/ring_phase_monitor.sv
// Ring phase monitor: one-hot to index, step legality, lock and rotation count.
// Optional: RING_PHASE_MON_AUTO_RELOCK_EN lets FAULT fall back to SYNC on a legal sample.
module ring_phase_monitor #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    parameter int ROT_W    = 8
) (
    input  logic                 clk,
    input  logic                 ori,
    input  logic [N-1:0]         ring,
    output logic [$clog2(N)-1:0] idx,
    output logic                 onehot_ok,
    output logic                 locked,
    output logic                 fault,
    output logic                 wrap,
    output logic [ROT_W-1:0]     rot_cnt
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [IW-1:0]  q, q_n;
    logic           vld, vld_n;
    logic [CW-1:0]  good, good_n;
    logic [ROT_W-1:0] rot_n;
    logic           wrap_n;

    logic           legal;
    logic [IW-1:0]  pos;
    logic [IW-1:0]  nxt;
    logic           adv;
    logic           hold;
    logic           jump;

    always_comb begin
        pos = '0;
        for (int i = 0; i < N; i++)
            if (ring[i])
                pos = IW'(i);
        legal = $onehot(ring);
        nxt   = (q == IW'(N - 1)) ? '0 : q + IW'(1);
        adv   = vld && legal && (pos == nxt);
        hold  = vld && legal && (pos == q);
        jump  = vld && legal && !adv && !hold;
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        vld_n   = vld;
        good_n  = good;
        rot_n   = rot_cnt;
        wrap_n  = 1'b0;
        unique case (state)
            SYNC: begin
                if (!legal) begin
                    good_n = '0;
                    vld_n  = 1'b0;
                end else if (!vld) begin
                    q_n   = pos;
                    vld_n = 1'b1;
                end else if (adv) begin
                    q_n = pos;
                    if (good == CW'(LOCK_CNT - 1)) begin
                        state_n = LOCKED;
                        good_n  = '0;
                    end else begin
                        good_n = good + CW'(1);
                    end
                end else if (jump) begin
                    good_n = '0;
                    q_n    = pos;
                end
            end
            LOCKED: begin
                if (!legal || jump || !vld) begin
                    state_n = FAULT;
                end else if (adv) begin
                    q_n = pos;
                    if (q == IW'(N - 1)) begin
                        wrap_n = 1'b1;
                        rot_n  = rot_cnt + ROT_W'(1);
                    end
                end
            end
            FAULT: begin
`ifdef RING_PHASE_MON_AUTO_RELOCK_EN
                if (legal) begin
                    state_n = SYNC;
                    good_n  = '0;
                    q_n     = pos;
                    vld_n   = 1'b1;
                end
`else
                state_n = FAULT;
`endif
            end
            default: state_n = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ori) begin
            state     <= SYNC;
            q         <= '0;
            vld       <= 1'b0;
            good      <= '0;
            idx       <= '0;
            onehot_ok <= 1'b0;
            wrap      <= 1'b0;
            rot_cnt   <= '0;
        end else begin
            state     <= state_n;
            q         <= q_n;
            vld       <= vld_n;
            good      <= good_n;
            onehot_ok <= legal;
            wrap      <= wrap_n;
            rot_cnt   <= rot_n;
            if (legal)
                idx <= pos;
        end
    end

    assign locked = (state == LOCKED);
    assign fault  = (state == FAULT);

endmodule
